// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter: two-master round-robin read arbiter in front of a
// combinational system-ID slave. One read is in flight at a time; data is
// registered and returned READ_LATENCY cycles after the accept cycle.
// Optional per-master grant counters are compiled in with SYSID_ARB_STATS_EN.
module sysid_read_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              m0_read,
    input  logic              m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              s_address,
    input  logic [DATA_W-1:0] s_readdata
`ifdef SYSID_ARB_STATS_EN
    ,
    output logic [15:0]       m0_grant_count,
    output logic [15:0]       m1_grant_count
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // A latency of one captures at the end of the accept cycle, so BUSY is never entered.
    localparam bit          SINGLE     = (READ_LATENCY == 1);
    localparam int          LAST_CNT_I = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;
    localparam logic [1:0]  LAST_CNT   = LAST_CNT_I[1:0];

`ifndef SYNTHESIS
    // Reject latencies the 2-bit counter cannot represent.
    initial begin
        if (READ_LATENCY < 1 || READ_LATENCY > 4)
            $error("sysid_read_arbiter: READ_LATENCY=%0d outside 1..4", READ_LATENCY);
    end
`endif

    state_t            state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              addr_q, addr_d;
    logic [DATA_W-1:0] m0_rd_q, m0_rd_d, m1_rd_q, m1_rd_d;
    logic              m0_rdv_q, m0_rdv_d, m1_rdv_q, m1_rdv_d;

    logic accept, win, acc0, acc1, win_addr, capture, cap_owner;

    // Arbitration: only an idle arbiter out of reset accepts; ties go to the master not granted last.
    always_comb begin
        accept    = reset_n & (state_q == IDLE) & (m0_read | m1_read);
        win       = (m0_read & m1_read) ? ~last_grant_q : ~m0_read;
        acc0      = accept & ~win;
        acc1      = accept & win;
        win_addr  = win ? m1_address : m0_address;
        capture   = (accept & SINGLE) | ((state_q == BUSY) & (count_q == LAST_CNT));
        cap_owner = (state_q == BUSY) ? owner_q : win;
        s_address = accept ? win_addr : ((state_q == BUSY) ? addr_q : 1'b0);
    end

    assign m0_waitrequest   = ~reset_n | (m0_read & ~acc0);
    assign m1_waitrequest   = ~reset_n | (m1_read & ~acc1);
    assign m0_readdata      = m0_rd_q;
    assign m1_readdata      = m1_rd_q;
    assign m0_readdatavalid = m0_rdv_q;
    assign m1_readdatavalid = m1_rdv_q;

    // Next-state: latch the winner on accept, count latency, capture slave data into the owner.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        m0_rd_d      = m0_rd_q;
        m1_rd_d      = m1_rd_q;
        m0_rdv_d     = 1'b0;
        m1_rdv_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d      = win;
                    addr_d       = win_addr;
                    last_grant_d = win;
                    count_d      = 2'd0;
                    state_d      = SINGLE ? IDLE : BUSY;
                end
            end
            BUSY: begin
                count_d = count_q + 2'd1;
                if (count_q == LAST_CNT)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            if (cap_owner) begin
                m1_rd_d  = s_readdata;
                m1_rdv_d = 1'b1;
            end else begin
                m0_rd_d  = s_readdata;
                m0_rdv_d = 1'b1;
            end
        end
    end

    // State register; reset abandons any in-flight read.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= 2'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= 1'b0;
            m0_rd_q      <= '0;
            m1_rd_q      <= '0;
            m0_rdv_q     <= 1'b0;
            m1_rdv_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            m0_rd_q      <= m0_rd_d;
            m1_rd_q      <= m1_rd_d;
            m0_rdv_q     <= m0_rdv_d;
            m1_rdv_q     <= m1_rdv_d;
        end
    end

`ifdef SYSID_ARB_STATS_EN
    logic [15:0] m0_grant_count_q, m0_grant_count_d;
    logic [15:0] m1_grant_count_q, m1_grant_count_d;

    // Saturating grant counters, one per master.
    always_comb begin
        m0_grant_count_d = m0_grant_count_q;
        m1_grant_count_d = m1_grant_count_q;
        if (acc0 && m0_grant_count_q != 16'hFFFF) m0_grant_count_d = m0_grant_count_q + 16'd1;
        if (acc1 && m1_grant_count_q != 16'hFFFF) m1_grant_count_d = m1_grant_count_q + 16'd1;
    end

    // Grant counter registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            m0_grant_count_q <= 16'd0;
            m1_grant_count_q <= 16'd0;
        end else begin
            m0_grant_count_q <= m0_grant_count_d;
            m1_grant_count_q <= m1_grant_count_d;
        end
    end

    assign m0_grant_count = m0_grant_count_q;
    assign m1_grant_count = m1_grant_count_q;
`endif

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Bench for sysid_read_arbiter: four instances (READ_LATENCY 1..4) share the
// same master stimulus; a transaction-level model per instance predicts every
// output each cycle, with directed literal checks on the interesting scenarios.
module tb_sysid_read_arbiter;
    localparam int N = 4;
    localparam logic [31:0] ID_WORD = 32'h5A8C537E;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n, m0_read, m0_address, m1_read, m1_address;
    logic [N-1:0] wr0, wr1, rdv0, rdv1, saddr;
    logic [31:0]  rd0 [N];
    logic [31:0]  rd1 [N];
    logic [31:0]  sdata [N];
`ifdef SYSID_ARB_STATS_EN
    logic [15:0]  gc0 [N];
    logic [15:0]  gc1 [N];
`endif

    for (genvar g = 0; g < N; g++) begin : gen_dut
        assign sdata[g] = saddr[g] ? ID_WORD : 32'h0;
        sysid_read_arbiter #(.READ_LATENCY(g + 1), .DATA_W(32)) u_dut (
            .clock(clock), .reset_n(reset_n),
            .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(wr0[g]),
            .m0_readdata(rd0[g]), .m0_readdatavalid(rdv0[g]),
            .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(wr1[g]),
            .m1_readdata(rd1[g]), .m1_readdatavalid(rdv1[g]),
            .s_address(saddr[g]), .s_readdata(sdata[g])
`ifdef SYSID_ARB_STATS_EN
            , .m0_grant_count(gc0[g]), .m1_grant_count(gc1[g])
`endif
        );
    end

    // Model: pend = cycles until the owner's data-valid cycle (-1 = nothing outstanding).
    int          m_pend [N];
    bit          m_owner [N];
    bit          m_addr [N];
    bit          m_last [N];
    logic [31:0] m_rd0 [N];
    logic [31:0] m_rd1 [N];
    int          m_gc0 [N];
    int          m_gc1 [N];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_pend[i] = -1; m_owner[i] = 0; m_addr[i] = 0; m_last[i] = 1;
        m_rd0[i] = 0; m_rd1[i] = 0; m_gc0[i] = 0; m_gc1[i] = 0;
    endtask

    // Compare every instance against its model at the falling edge, then advance the model.
    task automatic model_step();
        bit idle, acc, win, e_sa;
        string p;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            p    = $sformatf("L%0d", i + 1);
            idle = (m_pend[i] <= 0);
            acc  = reset_n && idle && (m0_read || m1_read);
            win  = (m0_read && m1_read) ? !m_last[i] : !m0_read;
            e_sa = acc ? (win ? m1_address : m0_address) : (idle ? 1'b0 : m_addr[i]);
            check({p, "_wr0"}, 32'(wr0[i]), 32'(!reset_n || (m0_read && !(acc && !win))));
            check({p, "_wr1"}, 32'(wr1[i]), 32'(!reset_n || (m1_read && !(acc && win))));
            check({p, "_saddr"}, 32'(saddr[i]), 32'(e_sa));
            check({p, "_rdv0"}, 32'(rdv0[i]), 32'(m_pend[i] == 0 && !m_owner[i]));
            check({p, "_rdv1"}, 32'(rdv1[i]), 32'(m_pend[i] == 0 && m_owner[i]));
            check({p, "_rd0"}, rd0[i], m_rd0[i]);
            check({p, "_rd1"}, rd1[i], m_rd1[i]);
`ifdef SYSID_ARB_STATS_EN
            check({p, "_gc0"}, 32'(gc0[i]), 32'(m_gc0[i]));
            check({p, "_gc1"}, 32'(gc1[i]), 32'(m_gc1[i]));
`endif
            if (!reset_n) begin
                model_reset(i);
            end else begin
                if (acc) begin
                    m_owner[i] = win;
                    m_addr[i]  = win ? m1_address : m0_address;
                    m_last[i]  = win;
                    m_pend[i]  = i;   // latency (i+1) minus the cycle just elapsed
                    if (win) m_gc1[i] = (m_gc1[i] == 65535) ? 65535 : m_gc1[i] + 1;
                    else     m_gc0[i] = (m_gc0[i] == 65535) ? 65535 : m_gc0[i] + 1;
                end else if (m_pend[i] >= 0) begin
                    m_pend[i]--;
                end
                if (m_pend[i] == 0) begin
                    if (m_owner[i]) m_rd1[i] = m_addr[i] ? ID_WORD : 32'h0;
                    else            m_rd0[i] = m_addr[i] ? ID_WORD : 32'h0;
                end
            end
        end
    endtask

    task automatic drive(input bit r0, input bit a0, input bit r1, input bit a1, input bit rn);
        m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1; reset_n = rn;
    endtask

    task automatic cyc(input bit r0, input bit a0, input bit r1, input bit a1, input bit rn);
        @(posedge clock);
        #1;
        drive(r0, a0, r1, a1, rn);
        model_step();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) model_reset(i);

        // Reset held with both masters requesting: both stalled, outputs at reset values.
        drive(1, 1, 1, 1, 0);
        model_step();
        check("rst_wr0", 32'(wr0[0]), 32'd1);
        check("rst_wr1", 32'(wr1[3]), 32'd1);
        check("rst_rdv0", 32'(rdv0[0]), 32'd0);
        check("rst_rd0", rd0[1], 32'h0);
        check("rst_saddr", 32'(saddr[0]), 32'd0);

        // Single m0 read of the ID word, latency 1.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        check("single_wr0", 32'(wr0[0]), 32'd0);
        check("single_saddr", 32'(saddr[0]), 32'd1);
        cyc(0, 0, 0, 0, 1);
        check("single_rdv0", 32'(rdv0[0]), 32'd1);
        check("single_rd0", rd0[0], ID_WORD);
        check("single_rdv1", 32'(rdv1[0]), 32'd0);
        check("single_rd1", rd1[0], 32'h0);

        // m1 reads the ID word so its data register is non-zero before the tie.
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
        check("m1_rd1", rd1[0], ID_WORD);

        // Tie: m0 (addr 1) beats m1 (addr 0); m1 accepted in m0's data-valid cycle.
        cyc(1, 1, 1, 0, 1);
        check("tie_wr0", 32'(wr0[0]), 32'd0);
        check("tie_wr1", 32'(wr1[0]), 32'd1);
        cyc(0, 0, 1, 0, 1);
        check("tie_rdv0", 32'(rdv0[0]), 32'd1);
        check("tie_rd0", rd0[0], ID_WORD);
        check("tie_wr1_acc", 32'(wr1[0]), 32'd0);
        cyc(0, 0, 0, 0, 1);
        check("tie_rdv1", 32'(rdv1[0]), 32'd1);
        check("tie_rd1", rd1[0], 32'h0);

        // Continuous contention, latency 3: accepts every 3 cycles alternating 0,1.
        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            cyc(1, 1, 1, 0, 1);
            check($sformatf("cont_wr0_%0d", k), 32'(wr0[2]), 32'(k % 6 != 0));
            check($sformatf("cont_wr1_%0d", k), 32'(wr1[2]), 32'(k % 6 != 3));
            check($sformatf("cont_rdv0_%0d", k), 32'(rdv0[2]), 32'(k % 6 == 3));
            check($sformatf("cont_rdv1_%0d", k), 32'(rdv1[2]), 32'(k % 6 == 0 && k != 0));
            check($sformatf("cont_both_%0d", k), 32'(rdv0[2] & rdv1[2]), 32'd0);
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Reset two cycles into a latency-4 m1 read: no data-valid, next tie to m0.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1);
        check("abort_acc_wr1", 32'(wr1[3]), 32'd0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1);
            check($sformatf("abort_rdv1_%0d", k), 32'(rdv1[3]), 32'd0);
        end
        cyc(1, 0, 1, 0, 1);
        check("abort_tie_wr0", 32'(wr0[3]), 32'd0);
        check("abort_tie_wr1", 32'(wr1[3]), 32'd1);

`ifdef SYSID_ARB_STATS_EN
        // Grant counting: 5 m0 accepts then 3 m1 accepts at latency 1.
        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
        check("stats_gc0", 32'(gc0[0]), 32'd5);
        check("stats_gc1", 32'(gc1[0]), 32'd3);
        // Saturation: preload 0xFFFF, then accept more m0 reads.
        @(posedge clock);
        #1;
        force gen_dut[0].u_dut.m0_grant_count_q = 16'hFFFF;
        m_gc0[0] = 65535;
        drive(1, 0, 0, 0, 1);
        model_step();
        @(posedge clock);
        #1;
        release gen_dut[0].u_dut.m0_grant_count_q;
        drive(1, 0, 0, 0, 1);
        model_step();
        cyc(0, 0, 0, 0, 1);
        check("stats_sat", 32'(gc0[0]), 32'h0000FFFF);
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 59) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
- Two-master round-robin read arbiter sharing one combinational system-ID slave (1-bit address, 32-bit readdata).
- Used where both the Nios II data master and a JTAG/debug master must read the ID/timestamp words.
- Registers slave data and returns it after a fixed latency, with Avalon-MM waitrequest/readdatavalid per master.
- One transaction in flight at a time.

Parameters:
- READ_LATENCY, 1, cycles from accept to readdatavalid; legal range 1..4.
- DATA_W, 32, readdata width.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- m0_read  in  1  master 0 read request
- m0_address  in  1  master 0 word address
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 return data
- m0_readdatavalid  out  1  master 0 data-valid pulse
- m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid  same as m0, for master 1
- s_address  out  1  address to the system-ID slave
- s_readdata  in  DATA_W  combinational slave data

Behaviour:
- Reset: one clock, synchronous, active-low; reset_n sampled only on rising clock.
- Reset values: state=IDLE, count=0, last_grant=1 (master 0 wins the first tie), m*_readdatavalid=0, m*_readdata=0, latched address=0.
- While reset_n=0, both waitrequests are held high combinationally, so no accept occurs.
- States:
  - IDLE: no read outstanding.
  - BUSY: read accepted, counting latency.
- Arbitration (IDLE only):
  - If exactly one mN_read is high, that master wins.
  - If both are high, the master != last_grant wins.
  - The winner's waitrequest is low that cycle; this is the accept cycle T.
- waitrequest rule: mN_waitrequest = mN_read & ~(accept of N this cycle). It is low when mN_read is low.
- In BUSY, both waitrequests stay high while their read is asserted. Masters must hold read and address stable while stalled; the arbiter does not check this.
- On accept: latch winner id and address; last_grant <= winner; count <= 0; state <= BUSY.
- s_address:
  - Equals the winner's address combinationally during the accept cycle.
  - Otherwise equals the latched address.
  - Is 0 in IDLE with no accept.
- BUSY:
  - count increments each cycle.
  - At the edge ending cycle T+READ_LATENCY-1, s_readdata is captured into the owner's mN_readdata.
  - The owner's readdatavalid is set for exactly one cycle, T+READ_LATENCY.
  - state returns to IDLE in that same cycle.
  - For READ_LATENCY=1, capture occurs at the end of the accept cycle itself.
- Back-to-back: a new accept may occur in the cycle readdatavalid is high. Peak throughput is one read per READ_LATENCY cycles.
- Non-owner readdata holds its previous value; its readdatavalid stays 0.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1…
- Reset mid-operation: the in-flight read is abandoned, no readdatavalid is issued, and the state returns to IDLE with reset values.
- Reads issued after reset are unaffected.
- Widths: count is 2 bits, sufficient for READ_LATENCY up to 4. Values of READ_LATENCY outside 1..4 are a parameter error and are flagged by a simulation-only initial check.

Optional Feature:
- Macro: SYSID_ARB_STATS_EN.
- When defined:
  - Adds outputs m0_grant_count and m1_grant_count (16 bits each).
  - Each counter increments on its master's accept and saturates at 0xFFFF.
  - Both reset to 0.
- When undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Slave model: address 0 returns 0x00000000, address 1 returns 0x5A8C537E. READ_LATENCY=1 unless stated.
- Single read: m0_read=1, m0_address=1 for one cycle → m0_waitrequest=0 in T; m0_readdatavalid=1 in T+1 with m0_readdata=0x5A8C537E; m1 outputs unchanged.
- Tie after reset: both masters read in the same cycle (m0 addr 1, m1 addr 0) → m0 accepted first, m1_waitrequest=1 until m0's readdatavalid cycle; m1 then receives 0x00000000 one cycle later.
- Continuous contention with READ_LATENCY=3: both masters hold read for 12 cycles → grants alternate 0,1,0,1; each readdatavalid arrives exactly 3 cycles after its accept; no cycle has both readdatavalids high.
- Reset mid-read with READ_LATENCY=4: accept a m1 read, drop reset_n in T+2 for one cycle → no m1_readdatavalid is seen. The next tie is won by m0 (last_grant reset to 1).
- Stats (SYSID_ARB_STATS_EN defined): issue 5 m0 accepts and 3 m1 accepts → m0_grant_count=5, m1_grant_count=3. Force a counter to 0xFFFF, issue another accept → it stays at 0xFFFF.
